// File: rtl/bench_batch_scheduler_pkg.sv
// Shared definitions for the benchmark batch scheduler: FSM encodings and
// engine time-lane geometry used to slice eng_t, sum_t and win_cnt.
package bench_batch_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_GAP    = 3'd4
  } sched_state_t;

  localparam int ENG_LANES = 4;
  localparam int ENG_T_W   = 32;

  function automatic logic [ENG_T_W-1:0] eng_lane(input logic [ENG_LANES*ENG_T_W-1:0] t,
                                                  input int lane);
    return t[lane*ENG_T_W +: ENG_T_W];
  endfunction

endpackage

// File: rtl/bench_sat_acc.sv
// Saturating accumulator: acc += din each enabled cycle, sticking at all-ones.
module bench_sat_acc #(
  parameter int WIDTH = 48,
  parameter int IN_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [WIDTH-1:0] acc
);

  localparam int EXT_W = WIDTH + 1;

  // One guard bit catches the carry out; IN_W must not exceed WIDTH.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc} + EXT_W'(din);

  always_ff @(posedge clk) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/bench_batch_scheduler.sv
// Batch sequencer for bench_engine: repeated start/done runs with saturating
// time sums and winner tallies. Optional WAIT timeout under BENCH_TIMEOUT_EN.
module bench_batch_scheduler
  import bench_batch_scheduler_pkg::*;
#(
  parameter int SUM_W       = 48,
  parameter int CNT_W       = 16,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_start,
  input  logic                         cmd_abort,
  input  logic [CNT_W-1:0]             cfg_runs,
  output logic                         busy,
  output logic                         batch_done,
  output logic                         err_timeout,
  output logic                         eng_start,
  input  logic                         eng_done,
  input  logic [ENG_LANES*ENG_T_W-1:0] eng_t,
  input  logic [1:0]                   eng_winner,
  output logic [CNT_W-1:0]             runs_done,
  output logic [ENG_LANES*SUM_W-1:0]   sum_t,
  output logic [ENG_LANES*CNT_W-1:0]   win_cnt
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  sched_state_t state, state_nxt;
  logic [CNT_W-1:0] runs_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic [ENG_LANES-1:0][CNT_W-1:0] win_q;
  logic accept, take, last_run, tmo;

  assign accept   = (state == S_IDLE) && cmd_start && (cfg_runs != '0);
  // Abort outranks a coincident done: that run is dropped.
  assign take     = (state == S_WAIT) && eng_done && !cmd_abort;
  assign last_run = (runs_done == runs_lat);

  assign busy      = (state != S_IDLE);
  assign eng_start = (state == S_LAUNCH);
  assign win_cnt   = win_q;

`ifdef BENCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  logic err_q;

  assign tmo         = (state == S_WAIT) && !eng_done && (to_cnt == TO_LAST);
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == S_WAIT) ? to_cnt + 1'b1 : '0;
      if (accept)                err_q <= 1'b0;
      else if (tmo && !cmd_abort) err_q <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (take)     state_nxt = S_NEXT;
        else if (tmo) state_nxt = S_IDLE;
      end
      S_NEXT: begin
        if (last_run)          state_nxt = S_IDLE;
        else if (GAP_CYC == 0) state_nxt = S_LAUNCH;
        else                   state_nxt = S_GAP;
      end
      S_GAP:    if (gap_cnt == GAP_LAST) state_nxt = S_LAUNCH;
      default:  state_nxt = S_IDLE;
    endcase
    if (cmd_abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      runs_lat   <= '0;
      runs_done  <= '0;
      gap_cnt    <= '0;
      batch_done <= 1'b0;
    end else begin
      if (accept) runs_lat <= cfg_runs;
      if (accept)    runs_done <= '0;
      else if (take) runs_done <= runs_done + 1'b1;
      gap_cnt    <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      batch_done <= (state == S_NEXT) && last_run && !cmd_abort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      for (int l = 0; l < ENG_LANES; l++) begin
        if (accept)
          win_q[l] <= '0;
        else if (take && (eng_winner == 2'(l)) && (win_q[l] != '1))
          win_q[l] <= win_q[l] + 1'b1;
      end
    end
  end

  for (genvar l = 0; l < ENG_LANES; l++) begin : g_lane
    bench_sat_acc #(
      .WIDTH(SUM_W),
      .IN_W (ENG_T_W)
    ) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (take),
      .din (eng_lane(eng_t, l)),
      .acc (sum_t[l*SUM_W +: SUM_W])
    );
  end

endmodule

// File: tb/tb_bench_batch_scheduler.sv
// Directed bench for bench_batch_scheduler: two instances (GAP_CYC 0 and 4,
// SUM_W 32) checked every cycle against an event-schedule model.
module tb_bench_batch_scheduler;

  localparam int SW = 32;
  localparam int CW = 16;
  localparam int TO = 50;
`ifdef BENCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]              cmd_start, cmd_abort, eng_done;
  logic [1:0][CW-1:0]      cfg_runs;
  logic [1:0][127:0]       eng_t;
  logic [1:0][1:0]         eng_winner;
  wire  [1:0]              busy, batch_done, err_timeout, eng_start;
  wire  [1:0][CW-1:0]      runs_done;
  wire  [1:0][4*SW-1:0]    sum_t;
  wire  [1:0][4*CW-1:0]    win_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bench_batch_scheduler #(
      .SUM_W(SW), .CNT_W(CW), .GAP_CYC(g*4), .TIMEOUT_CYC(TO)
    ) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start[g]), .cmd_abort(cmd_abort[g]),
      .cfg_runs(cfg_runs[g]), .busy(busy[g]), .batch_done(batch_done[g]),
      .err_timeout(err_timeout[g]), .eng_start(eng_start[g]), .eng_done(eng_done[g]),
      .eng_t(eng_t[g]), .eng_winner(eng_winner[g]), .runs_done(runs_done[g]),
      .sum_t(sum_t[g]), .win_cnt(win_cnt[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int pin = 0;

  // Engine stand-in: answers each eng_start after lat[i] cycles.
  bit auto_en[2];
  int lat[2];
  int due[2];

  // ---------------- model + compare (sole writer of the counters) ----------
  bit     m_valid = 1'b0;
  bit     m_busy[2], m_wait[2], m_err[2];
  int     m_start[2], m_wfrom[2], m_bd[2], m_off[2], m_n[2], m_runs[2];
  longint m_sum[2][4];
  int     m_win[2][4];
  int     nstart[2], nbd[2], last_done[2], bd_at[2];

  task automatic chk(input string nm, input int i, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_sum(input int i);
    logic [127:0] v;
    for (int l = 0; l < 4; l++) v[l*32 +: 32] = m_sum[i][l][31:0];
    return v;
  endfunction

  function automatic logic [63:0] exp_win(input int i);
    logic [63:0] v;
    for (int l = 0; l < 4; l++) v[l*16 +: 16] = 16'(m_win[i][l]);
    return v;
  endfunction

  task automatic model_clear(input int i);
    m_busy[i] = 1'b0; m_wait[i] = 1'b0; m_err[i] = 1'b0;
    m_start[i] = -1; m_wfrom[i] = -1; m_bd[i] = -1; m_off[i] = -1;
    m_n[i] = 0; m_runs[i] = 0;
    for (int l = 0; l < 4; l++) begin m_sum[i][l] = 0; m_win[i][l] = 0; end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid) begin
        if (cyc == m_off[i]) m_busy[i] = 1'b0;
        chk("busy",        i, 128'(busy[i]),        128'(m_busy[i]));
        chk("eng_start",   i, 128'(eng_start[i]),   128'(cyc == m_start[i]));
        chk("batch_done",  i, 128'(batch_done[i]),  128'(cyc == m_bd[i]));
        chk("err_timeout", i, 128'(err_timeout[i]), 128'(m_err[i]));
        chk("runs_done",   i, 128'(runs_done[i]),   128'(m_runs[i]));
        chk("sum_t",       i, 128'(sum_t[i]),       exp_sum(i));
        chk("win_cnt",     i, 128'(win_cnt[i]),     128'(exp_win(i)));
        nstart[i] += int'(eng_start[i]);
        nbd[i]    += int'(batch_done[i]);
        if (eng_done[i] && busy[i]) last_done[i] = cyc;
        if (batch_done[i]) bd_at[i] = cyc;
      end
      // Predict the next cycle from this cycle's inputs.
      if (rst) begin
        model_clear(i);
      end else if (!m_busy[i]) begin
        if (cmd_start[i] && cfg_runs[i] != '0) begin
          model_clear(i);
          m_busy[i] = 1'b1; m_n[i] = int'(cfg_runs[i]);
          m_start[i] = cyc + 1; m_wfrom[i] = cyc + 2; m_wait[i] = 1'b1;
        end
      end else if (cmd_abort[i]) begin
        m_busy[i] = 1'b0; m_wait[i] = 1'b0;
        m_start[i] = -1; m_bd[i] = -1; m_off[i] = -1;
      end else if (m_wait[i] && cyc >= m_wfrom[i]) begin
        if (eng_done[i]) begin
          for (int l = 0; l < 4; l++) begin
            m_sum[i][l] += longint'(eng_t[i][l*32 +: 32]);
            if (m_sum[i][l] > 64'hFFFF_FFFF) m_sum[i][l] = 64'hFFFF_FFFF;
          end
          if (m_win[i][eng_winner[i]] < 65535) m_win[i][eng_winner[i]]++;
          m_runs[i]++;
          if (m_runs[i] == m_n[i]) begin
            m_wait[i] = 1'b0; m_bd[i] = cyc + 2; m_off[i] = cyc + 2;
          end else begin
            m_start[i] = cyc + 2 + 4*i; m_wfrom[i] = cyc + 3 + 4*i;
          end
        end else if (TMO_EN && (cyc - m_wfrom[i] + 1 == TO)) begin
          m_err[i] = 1'b1; m_busy[i] = 1'b0; m_wait[i] = 1'b0;
        end
      end
    end
    if (rst) m_valid = 1'b1;

    // Hand-computed expectations that pin the model itself.
    case (pin)
      1: for (int i = 0; i < 2; i++) begin
        chk("rst_busy", i, 128'(busy[i]), 128'd0);
        chk("rst_runs", i, 128'(runs_done[i]), 128'd0);
        chk("rst_sum",  i, 128'(sum_t[i]), 128'd0);
        chk("rst_win",  i, 128'(win_cnt[i]), 128'd0);
      end
      2: begin
        chk("t1_runs",   0, 128'(runs_done[0]), 128'd3);
        chk("t1_sum",    0, 128'(sum_t[0]), {32'd120, 32'd90, 32'd60, 32'd30});
        chk("t1_win",    0, 128'(win_cnt[0]), 128'({16'd3, 16'd0, 16'd0, 16'd0}));
        chk("t1_starts", 0, 128'(nstart[0]), 128'd3);
        chk("t1_bdones", 0, 128'(nbd[0]), 128'd1);
        chk("t1_bd_lag", 0, 128'(bd_at[0] - last_done[0]), 128'd2);
        chk("t1_busy",   0, 128'(busy[0]), 128'd0);
      end
      3: begin
        chk("t3_sum",    0, 128'(sum_t[0]), {32'd14, 32'd10, 32'd6, 32'hFFFF_FFFF});
        chk("t3_win",    0, 128'(win_cnt[0]), 128'({16'd0, 16'd0, 16'd2, 16'd0}));
        chk("t3_bdones", 0, 128'(nbd[0]), 128'd2);
      end
      4: begin
        chk("t2_busy",   1, 128'(busy[1]), 128'd0);
        chk("t2_runs",   1, 128'(runs_done[1]), 128'd1);
        chk("t2_sum",    1, 128'(sum_t[1]), {32'd1, 32'd2, 32'd3, 32'd4});
        chk("t2_bdones", 1, 128'(nbd[1]), 128'd0);
        chk("t2_starts", 1, 128'(nstart[1]), 128'd2);
      end
      5: begin
        chk("t4_runs",   1, 128'(runs_done[1]), 128'd3);
        chk("t4_sum",    1, 128'(sum_t[1]), {32'd3, 32'd3, 32'd3, 32'd3});
        chk("t4_win",    1, 128'(win_cnt[1]), 128'({16'd0, 16'd3, 16'd0, 16'd0}));
        chk("t4_bdones", 1, 128'(nbd[1]), 128'd1);
      end
      6: begin
        chk("t5_busy",   1, 128'(busy[1]), 128'd0);
        chk("t5_runs",   1, 128'(runs_done[1]), 128'd3);
        chk("t5_starts", 1, 128'(nstart[1]), 128'd5);
        chk("t5_sum",    1, 128'(sum_t[1]), {32'd3, 32'd3, 32'd3, 32'd3});
      end
      7: begin
        chk("t6_err",    1, 128'(err_timeout[1]), 128'(TMO_EN));
        chk("t6_busy",   1, 128'(busy[1]), 128'd0);
        chk("t6_bdones", 1, 128'(nbd[1]), 128'd1);
      end
      8: begin
        chk("t6_errclr", 1, 128'(err_timeout[1]), 128'd0);
        chk("t6_start",  1, 128'(eng_start[1]), 128'd1);
      end
      9: for (int i = 0; i < 2; i++) begin
        chk("rst_mid_busy", i, 128'(busy[i]), 128'd0);
        chk("rst_mid_runs", i, 128'(runs_done[i]), 128'd0);
        chk("rst_mid_sum",  i, 128'(sum_t[i]), 128'd0);
      end
      default: ;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cmd_start = '0;
    cmd_abort = '0;
    pin = 0;
    for (int i = 0; i < 2; i++) begin
      eng_done[i] = auto_en[i] && (cyc == due[i]);
      if (eng_start[i]) due[i] = cyc + lat[i];
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start_batch(input int i, input int runs);
    step();
    cfg_runs[i]  = CW'(runs);
    cmd_start[i] = 1'b1;
  endtask

  initial begin
    cmd_start = '0; cmd_abort = '0; eng_done = '0;
    cfg_runs = '0; eng_t = '0; eng_winner = '0;
    for (int i = 0; i < 2; i++) begin auto_en[i] = 1'b1; lat[i] = 3; due[i] = -1; end
    run(3);
    rst = 1'b0;
    step(); pin = 1;

    // 1: three runs, no gap
    eng_t[0] = {32'd40, 32'd30, 32'd20, 32'd10}; eng_winner[0] = 2'd3;
    start_batch(0, 3);
    run(30); pin = 2;

    // 3: lane0 saturation
    eng_t[0] = {32'd7, 32'd5, 32'd3, 32'hFFFF_FFFF}; eng_winner[0] = 2'd1;
    start_batch(0, 2);
    run(25); pin = 3;

    // 2: abort inside the second WAIT (gap 4)
    lat[1] = 5; eng_t[1] = {32'd1, 32'd2, 32'd3, 32'd4}; eng_winner[1] = 2'd0;
    start_batch(1, 5);
    run(14); cmd_abort[1] = 1'b1;
    run(20); pin = 4;

    // 4: start while busy, stray done in GAP
    lat[1] = 2; eng_t[1] = {32'd1, 32'd1, 32'd1, 32'd1}; eng_winner[1] = 2'd2;
    start_batch(1, 3);
    run(3); cfg_runs[1] = 16'd7; cmd_start[1] = 1'b1;
    run(3); eng_done[1] = 1'b1; cmd_start[1] = 1'b1;
    run(30); pin = 5;

    // 5: zero-run start ignored
    start_batch(1, 0);
    run(5); pin = 6;

    // 6: engine never answers
    auto_en[1] = 1'b0;
    start_batch(1, 2);
    run(60); cmd_abort[1] = 1'b1;
    run(2); pin = 7;
    auto_en[1] = 1'b1; lat[1] = 1;
    start_batch(1, 1);
    step(); pin = 8;
    run(10);

    // reset in the middle of a batch
    lat[0] = 3;
    start_batch(0, 4);
    run(7); rst = 1'b1;
    step(); rst = 1'b0; pin = 9;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
